// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU result path.
//   - op codes (same encoding as the 8-way result mux select)
//   - bit positions of the {N,Z,C,V} flag vector
//   - output-stage state encoding
//   - is_arith(): true for ops whose carry/overflow are meaningful
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational N/Z/C/V derivation for one ALU result.
// Ports:
//   op     in  3      op code of the result
//   result in  WIDTH  selected ALU result
//   carry  in  1      adder carry-out / not-borrow
//   ovf    in  1      adder signed overflow
//   flags  out 4      {N,Z,C,V}
// Carry and overflow only carry meaning for ADD/SUB; every other op
// reports them as 0 so stale adder outputs never leak into the flags.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  input  logic             ovf,
  output logic [3:0]       flags
);

  always_comb begin
    flags        = 4'b0000;
    flags[FLG_N] = result[WIDTH-1];
    flags[FLG_Z] = (result == '0);
    flags[FLG_C] = is_arith(op) & carry;
    flags[FLG_V] = is_arith(op) & ovf;
  end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the ALU result mux.
// Captures result, op and derived flags into a main register (M) with a
// one-entry skid register (S) behind it, so in_ready is a flop output and
// never depends combinationally on out_ready.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid/in_ready     upstream handshake (in_ready = ~skid_valid)
//   in_op, in_result      op code and mux output
//   in_carry, in_ovf      adder carry/not-borrow and signed overflow
//   out_valid/out_ready   consumer handshake
//   out_result, out_op    registered result and op code
//   out_flags             registered {N,Z,C,V}
//   done_cnt              results accepted by the consumer (wraps)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid may not be observed until ready; the
// stage keeps out_* stable while out_valid=1 and out_ready=0.
//
// Internal signal `state` (EMPTY/ONE/FULL) is the occupancy of M/S and is
// the intended observation point for assertions.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_op,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] done_cnt
);

  state_t           state;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_result;
  logic [2:0]       skid_op;
  logic [3:0]       skid_flags;
  logic [3:0]       in_flags;
  logic             accept;
  logic             deliver;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .op     (in_op),
    .result (in_result),
    .carry  (in_carry),
    .ovf    (in_ovf),
    .flags  (in_flags)
  );

  assign in_ready  = ~skid_valid;
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_EMPTY;
      skid_valid  <= 1'b0;
      out_result  <= '0;
      out_op      <= '0;
      out_flags   <= '0;
      skid_result <= '0;
      skid_op     <= '0;
      skid_flags  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_result <= in_result;
            out_op     <= in_op;
            out_flags  <= in_flags;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && deliver) begin
            out_result <= in_result;
            out_op     <= in_op;
            out_flags  <= in_flags;
          end else if (accept) begin
            // Consumer stalled: park the new entry so M stays stable.
            skid_result <= in_result;
            skid_op     <= in_op;
            skid_flags  <= in_flags;
            skid_valid  <= 1'b1;
            state       <= ST_FULL;
          end else if (deliver) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (deliver) begin
            out_result <= skid_result;
            out_op     <= skid_op;
            out_flags  <= skid_flags;
            skid_valid <= 1'b0;
            state      <= ST_ONE;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (deliver) begin
      done_cnt <= done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
